pc_gen_ras: RTL
===============

Name: pc_gen_ras

Overview:
Parametrised next-generation program counter for the fetch stage. It supports:
- sequential advance of 2 or 4 bytes;
- jump/branch redirect from the ALU;
- call/return redirect through a small circular return-address stack (RAS);
- trap redirect, including automatic trapping on misaligned targets.

It drives the instruction-memory address and keeps an exception PC (EPC) for the trap handler.

Parameters:
ADDR_WIDTH, 32, width of all addresses.
RESET_VECTOR, 32'h0000_0000, pc_out value on reset.
TRAP_VECTOR, 32'h0000_0100, target on trap or misaligned redirect.
RAS_DEPTH, 4, RAS entries; must be a power of 2, at least 2.
SUPPORT_C, 0. When 1, 16-bit instructions are supported: 2-byte alignment and step of 2 allowed.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst_n  in  1  asynchronous active-low reset.
en  in  1  advance enable; 0 = stall, all state held except on trap_en.
inst_16  in  1  current instruction is 16-bit; ignored when SUPPORT_C=0.
jump_en  in  1  redirect to alu_out.
call_en  in  1  jump to alu_out and push the link address.
ret_en  in  1  pop the RAS and jump to the popped address.
alu_out  in  ADDR_WIDTH  jump target; also the fallback target when ret_en finds the RAS empty.
trap_en  in  1  synchronous trap request; ignores en.
pc_out  out  ADDR_WIDTH  current PC (registered).
epc_out  out  ADDR_WIDTH  PC captured on the last trap or misalign.
misaligned  out  1  one-cycle registered pulse after a misaligned redirect.
ras_empty  out  1  RAS count is 0.
ras_count  out  $clog2(RAS_DEPTH)+1  valid RAS entries.

Behaviour:
- Reset (async, any time, including mid-redirect):
  - pc_out = RESET_VECTOR, epc_out = 0, misaligned = 0;
  - RAS count = 0, RAS pointer = 0, ras_empty = 1.
  - RAS contents are don't-care.
- step = 2 when SUPPORT_C=1 and inst_16=1, else 4.
- link = pc_out + step.
- All arithmetic is modulo 2^ADDR_WIDTH: wrap-around from all-ones to low addresses is legal and silent.
- Alignment check: target is misaligned when target[1:0]!=0 (SUPPORT_C=0) or target[0]!=0 (SUPPORT_C=1).
- Per rising edge, first matching row applies:
  1. trap_en=1 → pc_out<=TRAP_VECTOR, epc_out<=pc_out, RAS unchanged. Applies regardless of en.
  2. en=0 → hold everything; misaligned<=0.
  3. ret_en=1 → target = RAS top if count>0, else alu_out. If count>0, pop (count-1). If call_en is also 1, the link is pushed after the pop (net count unchanged when non-empty).
  4. jump_en=1 or call_en=1 → target = alu_out. call_en pushes link.
  5. Otherwise → pc_out <= link.
- Redirect commit (rows 3–4):
  - If the target is aligned, pc_out <= target.
  - If the target is misaligned: pc_out<=TRAP_VECTOR, epc_out<=pc_out, misaligned<=1 for exactly one cycle. The RAS is not modified (the pop and push are both cancelled).
- misaligned deasserts on the next edge unless re-triggered.
- RAS push:
  - write at the pointer, then pointer+1 mod RAS_DEPTH;
  - count saturates at RAS_DEPTH;
  - push when full silently overwrites the oldest entry.
- RAS pop: pointer-1, read that entry, count-1.
- Push of a full RAS combined with a pop in the same cycle: the pop completes first, so nothing is lost.
- No combinational path from inputs to outputs; all outputs are registers or decodes of register state.

Test Plan:
- Reset then en=1 for 3 edges (RESET_VECTOR=0) → pc_out 0→4→8→C; ras_empty=1; misaligned=0.
- At pc=8: call_en=1, alu_out=CAFE_BAB0 → pc=CAFE_BAB0, ras_count=1. Two sequential edges → CAFE_BAB8. ret_en=1 → pc=0000_000C, ras_count=0.
- 5 calls with RAS_DEPTH=4 from pcs 0,100,200,300,400 → count saturates at 4. Then 5 rets, alu_out=DEAD_0000 → targets 404,304,204,104, then DEAD_0000 on the empty-RAS fallback.
- jump_en=1, alu_out=CAFE_BABE (SUPPORT_C=0) at pc=C → pc=0000_0100, epc=C, misaligned high for exactly one cycle. Repeat with SUPPORT_C=1, alu_out=CAFE_BABE → pc=CAFE_BABE; then inst_16=1 → CAFE_BAC0.
- en=0 with jump_en=1 → pc held. Then trap_en=1 with en=0 at pc=20 → pc=100, epc=20. Sequential run from pc=FFFF_FFFC → wraps to 0000_0000.
- Assert rst_n low asynchronously mid-cycle during a call → pc_out=RESET_VECTOR immediately (before the next edge); ras_count=0.

Source files
------------

// File: rtl/pc_gen_ras.sv
// Fetch-stage next-PC generator: sequential step, ALU redirect, call/return
// through a circular return-address stack, and trap / misaligned-target redirect.
module pc_gen_ras #(
  parameter int unsigned            ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0]  RESET_VECTOR = 32'h0000_0000,
  parameter logic [ADDR_WIDTH-1:0]  TRAP_VECTOR  = 32'h0000_0100,
  parameter int unsigned            RAS_DEPTH    = 4,
  parameter bit                     SUPPORT_C    = 1'b0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic                        inst_16,
  input  logic                        jump_en,
  input  logic                        call_en,
  input  logic                        ret_en,
  input  logic [ADDR_WIDTH-1:0]       alu_out,
  input  logic                        trap_en,
  output logic [ADDR_WIDTH-1:0]       pc_out,
  output logic [ADDR_WIDTH-1:0]       epc_out,
  output logic                        misaligned,
  output logic                        ras_empty,
  output logic [$clog2(RAS_DEPTH):0]  ras_count
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef logic [ADDR_WIDTH-1:0] addr_t;

  addr_t                   pc_q, epc_q;
  logic                    mis_q;
  addr_t [RAS_DEPTH-1:0]   ras_q;
  logic [PTR_W-1:0]        ptr_q;
  logic [CNT_W-1:0]        cnt_q;

  addr_t            step, link, target;
  logic             have, redirect, bad, do_pop, do_push, adv;
  logic [PTR_W-1:0] ptr_dec, ptr_pop;
  logic [CNT_W-1:0] cnt_pop;

  always_comb begin
    step     = (SUPPORT_C && inst_16) ? addr_t'(2) : addr_t'(4);
    link     = pc_q + step;
    have     = (cnt_q != '0);
    redirect = ret_en | jump_en | call_en;
    ptr_dec  = ptr_q - PTR_W'(1);
    target   = (ret_en && have) ? ras_q[ptr_dec] : alu_out;
    bad      = SUPPORT_C ? target[0] : (target[1:0] != 2'b00);
    // A misaligned redirect cancels both the pop and the push.
    do_pop   = ret_en & have & ~bad;
    do_push  = call_en & ~bad;
    ptr_pop  = do_pop ? ptr_dec : ptr_q;
    cnt_pop  = do_pop ? (cnt_q - CNT_W'(1)) : cnt_q;
    adv      = en & ~trap_en;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= RESET_VECTOR;
      epc_q <= '0;
      mis_q <= 1'b0;
      ptr_q <= '0;
      cnt_q <= '0;
    end else if (trap_en) begin
      pc_q  <= TRAP_VECTOR;
      epc_q <= pc_q;
      mis_q <= 1'b0;
    end else if (!en) begin
      mis_q <= 1'b0;
    end else if (redirect && bad) begin
      pc_q  <= TRAP_VECTOR;
      epc_q <= pc_q;
      mis_q <= 1'b1;
    end else begin
      mis_q <= 1'b0;
      pc_q  <= redirect ? target : link;
      // Pop is applied first, so a push onto a full stack in the same cycle loses nothing.
      if (do_push) begin
        ptr_q <= ptr_pop + PTR_W'(1);
        cnt_q <= (cnt_pop == CNT_W'(RAS_DEPTH)) ? cnt_pop : (cnt_pop + CNT_W'(1));
      end else if (do_pop) begin
        ptr_q <= ptr_pop;
        cnt_q <= cnt_pop;
      end
    end
  end

  // Stack contents carry no reset; validity is tracked by cnt_q alone.
  always_ff @(posedge clk) begin
    if (adv && do_push) ras_q[ptr_pop] <= link;
  end

  assign pc_out     = pc_q;
  assign epc_out    = epc_q;
  assign misaligned = mis_q;
  assign ras_empty  = (cnt_q == '0);
  assign ras_count  = cnt_q;

endmodule
